// File: rtl/wb_arb_pkg.sv
// Shared types for the Wishbone burst arbiter: FSM states, CTI codes, watchdog width.
// No logic here beyond a one-hot to index helper.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWNED = 2'd1,
        ST_ABORT = 2'd2
    } arb_state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam int WDOG_W      = 16;
    localparam int IDX_W       = 4;
    localparam int MAX_MASTERS = 16;

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_MASTERS-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_MASTERS; i++) begin
            if (oh[i]) idx = idx | IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Round-robin search: first requester strictly after the last owner, wrapping.
// Purely combinational; no backpressure.
module wb_rr_pick
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 4
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]       last,
    output logic [NUM_MASTERS-1:0] gnt
);

    logic found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            for (int k = 0; k < NUM_MASTERS; k++) begin
                if (!found && req[k] && (k == (int'(last) + 1 + i) % NUM_MASTERS)) begin
                    gnt[k] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/wb_burst_arbiter.sv
// N-master to 1-slave Wishbone arbiter with round-robin grant, burst hold and response watchdog.
// Grant one cycle after request is sampled in IDLE; slave stalls are passed straight through to the owner.
module wb_burst_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int DW          = 32,
    parameter int AW          = 32,
    parameter int TIMEOUT     = 255
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_ni,
    input  logic [NUM_MASTERS*AW-1:0]   wbm_adr_i,
    input  logic [NUM_MASTERS*DW-1:0]   wbm_dat_i,
    input  logic [NUM_MASTERS*DW/8-1:0] wbm_sel_i,
    input  logic [NUM_MASTERS-1:0]      wbm_we_i,
    input  logic [NUM_MASTERS-1:0]      wbm_cyc_i,
    input  logic [NUM_MASTERS-1:0]      wbm_stb_i,
    input  logic [NUM_MASTERS*3-1:0]    wbm_cti_i,
    input  logic [NUM_MASTERS*2-1:0]    wbm_bte_i,
    output logic [NUM_MASTERS*DW-1:0]   wbm_dat_o,
    output logic [NUM_MASTERS-1:0]      wbm_ack_o,
    output logic [NUM_MASTERS-1:0]      wbm_err_o,
    output logic [NUM_MASTERS-1:0]      wbm_rty_o,
    output logic [AW-1:0]               wbs_adr_o,
    output logic [DW-1:0]               wbs_dat_o,
    output logic [DW/8-1:0]             wbs_sel_o,
    output logic                        wbs_we_o,
    output logic                        wbs_cyc_o,
    output logic                        wbs_stb_o,
    output logic [2:0]                  wbs_cti_o,
    output logic [1:0]                  wbs_bte_o,
    input  logic [DW-1:0]               wbs_dat_i,
    input  logic                        wbs_ack_i,
    input  logic                        wbs_err_i,
    input  logic                        wbs_rty_i,
    output logic [NUM_MASTERS-1:0]      grant_o,
    output logic                        timeout_o
);

    arb_state_t             state;
    logic [IDX_W-1:0]       owner;
    logic [IDX_W-1:0]       last_ptr;
    logic [WDOG_W-1:0]      wdog;
    logic [WDOG_W-1:0]      wdog_inc;
    logic                   abort_pulse;
    logic [NUM_MASTERS-1:0] pick;
    logic [MAX_MASTERS-1:0] pick_wide;
    logic                   owned;
    logic                   own_cyc;
    logic                   own_stb;
    logic                   slv_resp;

    wb_rr_pick #(
        .NUM_MASTERS (NUM_MASTERS)
    ) u_pick (
        .req  (wbm_cyc_i),
        .last (last_ptr),
        .gnt  (pick)
    );

    always_comb begin
        pick_wide                  = '0;
        pick_wide[NUM_MASTERS-1:0] = pick;
    end

    always_comb begin
        wbs_adr_o = '0;
        wbs_dat_o = '0;
        wbs_sel_o = '0;
        wbs_we_o  = 1'b0;
        wbs_cti_o = '0;
        wbs_bte_o = '0;
        own_cyc   = 1'b0;
        own_stb   = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (owner == IDX_W'(k)) begin
                wbs_adr_o = wbm_adr_i[k*AW +: AW];
                wbs_dat_o = wbm_dat_i[k*DW +: DW];
                wbs_sel_o = wbm_sel_i[k*(DW/8) +: DW/8];
                wbs_we_o  = wbm_we_i[k];
                wbs_cti_o = wbm_cti_i[k*3 +: 3];
                wbs_bte_o = wbm_bte_i[k*2 +: 2];
                own_cyc   = wbm_cyc_i[k];
                own_stb   = wbm_stb_i[k];
            end
        end
    end

    // Only OWNED drives the slave; ABORT and IDLE hold cyc/stb low so late responses go nowhere.
    assign owned     = (state == ST_OWNED);
    assign wbs_cyc_o = owned & own_cyc;
    assign wbs_stb_o = owned & own_stb;
    assign slv_resp  = wbs_ack_i | wbs_err_i | wbs_rty_i;
    assign timeout_o = abort_pulse;
    assign wdog_inc  = wdog + WDOG_W'(1);

    always_comb begin
        wbm_dat_o = '0;
        wbm_ack_o = '0;
        wbm_err_o = '0;
        wbm_rty_o = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            wbm_dat_o[k*DW +: DW] = wbs_dat_i;
            if (owner == IDX_W'(k)) begin
                wbm_ack_o[k] = owned & wbs_ack_i;
                wbm_rty_o[k] = owned & wbs_rty_i;
                wbm_err_o[k] = (owned & wbs_err_i) | abort_pulse;
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state       <= ST_IDLE;
            grant_o     <= '0;
            owner       <= '0;
            last_ptr    <= IDX_W'(NUM_MASTERS - 1);
            wdog        <= '0;
            abort_pulse <= 1'b0;
        end else begin
            abort_pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    wdog <= '0;
                    if (|wbm_cyc_i) begin
                        grant_o <= pick;
                        owner   <= onehot_to_idx(pick_wide);
                        state   <= ST_OWNED;
                    end
                end
                ST_OWNED: begin
                    if (!own_cyc) begin
                        state    <= ST_IDLE;
                        grant_o  <= '0;
                        last_ptr <= owner;
                        wdog     <= '0;
                    end else if (slv_resp) begin
                        wdog <= '0;
                    end else if (wbs_stb_o) begin
                        if (wdog_inc == WDOG_W'(TIMEOUT)) begin
                            state       <= ST_ABORT;
                            abort_pulse <= 1'b1;
                            wdog        <= '0;
                        end else begin
                            wdog <= wdog_inc;
                        end
                    end
                end
                ST_ABORT: begin
                    if (!own_cyc) begin
                        state    <= ST_IDLE;
                        grant_o  <= '0;
                        last_ptr <= owner;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_burst_arbiter.sv
// Scoreboard bench for wb_burst_arbiter: 4 masters, TIMEOUT=8, behavioural slave with programmable ack delay.
module tb_wb_burst_arbiter;
    import wb_arb_pkg::*;

    localparam int NM = 4;
    localparam logic [31:0] DKEY = 32'hA5A5_0000;

    logic             wb_clk_i = 1'b0;
    logic             wb_rst_ni;
    logic [NM*32-1:0] wbm_adr_i, wbm_dat_i, wbm_dat_o;
    logic [NM*4-1:0]  wbm_sel_i;
    logic [NM-1:0]    wbm_we_i, wbm_cyc_i, wbm_stb_i;
    logic [NM*3-1:0]  wbm_cti_i;
    logic [NM*2-1:0]  wbm_bte_i;
    logic [NM-1:0]    wbm_ack_o, wbm_err_o, wbm_rty_o;
    logic [31:0]      wbs_adr_o, wbs_dat_o, wbs_dat_i;
    logic [3:0]       wbs_sel_o;
    logic             wbs_we_o, wbs_cyc_o, wbs_stb_o;
    logic [2:0]       wbs_cti_o;
    logic [1:0]       wbs_bte_o;
    logic             wbs_ack_i, wbs_err_i, wbs_rty_i;
    logic [NM-1:0]    grant_o;
    logic             timeout_o;

    wb_burst_arbiter #(.NUM_MASTERS(NM), .DW(32), .AW(32), .TIMEOUT(8)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni),
        .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i),
        .wbm_we_i(wbm_we_i), .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i),
        .wbm_cti_i(wbm_cti_i), .wbm_bte_i(wbm_bte_i),
        .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o), .wbm_rty_o(wbm_rty_o),
        .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o), .wbs_we_o(wbs_we_o),
        .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o),
        .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i), .wbs_rty_i(wbs_rty_i),
        .grant_o(grant_o), .timeout_o(timeout_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] dat;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] glog[$];
    logic [3:0] prev_g = '0;
    int         n_chk = 0, n_pass = 0;
    int         ack_cnt[NM], err_cnt[NM], to_cnt;
    int         slv_delay = 1;
    bit         slv_dead = 0, slv_late = 0, abort_all = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic push_exp(input int id, input logic [31:0] adr);
        exp_t e;
        e.id  = 4'(id);
        e.dat = adr ^ DKEY;
        exp_q.push_back(e);
    endtask

    task automatic clear_logs();
        exp_q.delete();
        glog.delete();
        to_cnt = 0;
        for (int k = 0; k < NM; k++) begin
            ack_cnt[k] = 0;
            err_cnt[k] = 0;
        end
    endtask

    task automatic do_reset();
        wb_rst_ni = 1'b0;
        abort_all = 0; slv_late = 0; slv_dead = 0; slv_delay = 1;
        wbm_cyc_i = '0; wbm_stb_i = '0; wbm_cti_i = '0;
        repeat (3) @(posedge wb_clk_i);
        #1 wb_rst_ni = 1'b1;
        clear_logs();
    endtask

    // Called at posedge+1; returns at posedge+1 one cycle after cyc is dropped.
    task automatic master_txn(input int m, input int nbeats, input logic [31:0] adr);
        logic done;
        int   waitc;
        for (int b = 0; b < nbeats && !abort_all; b++) begin
            wbm_cyc_i[m] = 1'b1;
            wbm_stb_i[m] = 1'b1;
            wbm_adr_i[m*32 +: 32] = adr + 32'(4 * b);
            wbm_cti_i[m*3 +: 3] = (nbeats == 1) ? CTI_CLASSIC : ((b == nbeats - 1) ? CTI_EOB : CTI_INCR);
            done = 1'b0;
            waitc = 0;
            while (!done && !abort_all && waitc < 200) begin
                @(negedge wb_clk_i);
                done = wbm_ack_o[m] | wbm_err_o[m];
                waitc++;
                @(posedge wb_clk_i);
                #1;
            end
            if (!abort_all) check($sformatf("m%0d_beat%0d_done", m, b), 64'(done), 64'd1);
        end
        wbm_cyc_i[m] = 1'b0;
        wbm_stb_i[m] = 1'b0;
        wbm_cti_i[m*3 +: 3] = CTI_CLASSIC;
        @(posedge wb_clk_i);
        #1;
    endtask

    // Registered slave: acks once the strobe has been seen for slv_delay cycles.
    initial begin
        int          wcnt;
        logic        nack;
        logic [31:0] ndat;
        wcnt = 0; ndat = '0;
        wbs_ack_i = 0; wbs_err_i = 0; wbs_rty_i = 0; wbs_dat_i = '0;
        forever begin
            @(negedge wb_clk_i);
            nack = 1'b0;
            if (wbs_cyc_o && wbs_stb_o && !wbs_ack_i && !slv_dead) begin
                wcnt++;
                if (wcnt >= slv_delay) begin
                    nack = 1'b1;
                    wcnt = 0;
                    ndat = wbs_adr_o ^ DKEY;
                end
            end else begin
                wcnt = 0;
            end
            if (slv_late) nack = 1'b1;
            @(posedge wb_clk_i);
            #1;
            wbs_ack_i = nack;
            wbs_dat_i = ndat;
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge wb_clk_i);
            if (timeout_o) to_cnt++;
            if (grant_o != prev_g) begin
                if (grant_o != '0) glog.push_back(grant_o);
                prev_g = grant_o;
            end
            for (int k = 0; k < NM; k++) begin
                if (wbm_err_o[k]) err_cnt[k]++;
                if (wbm_ack_o[k]) begin
                    ack_cnt[k]++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_ack", 64'(k), 64'hff);
                    end else begin
                        e = exp_q.pop_front();
                        check("ack_master", 64'(k), 64'(e.id));
                        check("ack_data", 64'(wbm_dat_o[k*32 +: 32]), 64'(e.dat));
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not complete, n_chk=%0d", n_chk);
        $fatal(1);
    end

    initial begin
        wb_rst_ni = 1'b0;
        wbm_adr_i = '0; wbm_dat_i = '0; wbm_sel_i = '1; wbm_we_i = '0;
        wbm_cyc_i = '0; wbm_stb_i = '0; wbm_cti_i = '0; wbm_bte_i = '0;
        clear_logs();

        // Reset values
        repeat (2) @(negedge wb_clk_i);
        check("rst_grant", 64'(grant_o), 64'd0);
        check("rst_cyc", 64'(wbs_cyc_o), 64'd0);
        check("rst_stb", 64'(wbs_stb_o), 64'd0);
        check("rst_ack", 64'(wbm_ack_o), 64'd0);
        check("rst_err", 64'(wbm_err_o), 64'd0);
        check("rst_rty", 64'(wbm_rty_o), 64'd0);
        check("rst_timeout", 64'(timeout_o), 64'd0);

        // Single classic read from master 2, slave waits 3 cycles
        do_reset();
        slv_delay = 3;
        push_exp(2, 32'h0000_2200);
        fork
            master_txn(2, 1, 32'h0000_2200);
            begin
                @(negedge wb_clk_i);
                check("t2_cyc_before_grant", 64'(wbs_cyc_o), 64'd0);
                @(negedge wb_clk_i);
                check("t2_cyc_after_grant", 64'(wbs_cyc_o), 64'd1);
                check("t2_grant", 64'(grant_o), 64'b0100);
            end
        join
        @(negedge wb_clk_i);
        check("t2_grant_released", 64'(grant_o), 64'd0);
        check("t2_ack_once", 64'(ack_cnt[2]), 64'd1);
        check("t2_sb_empty", 64'(exp_q.size()), 64'd0);

        // All four masters request continuously from reset
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int m = 0; m < NM; m++) push_exp(m, 32'h1000 * (m + 1) + 32'h100 * r);
        fork
            begin master_txn(0, 1, 32'h1000); master_txn(0, 1, 32'h1100); end
            begin master_txn(1, 1, 32'h2000); master_txn(1, 1, 32'h2100); end
            begin master_txn(2, 1, 32'h3000); master_txn(2, 1, 32'h3100); end
            begin master_txn(3, 1, 32'h4000); master_txn(3, 1, 32'h4100); end
        join
        @(negedge wb_clk_i);
        check("t3_grant_count", 64'(glog.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            logic [3:0] want;
            want = 4'b0001 << (i % 4);
            check($sformatf("t3_grant_%0d", i), 64'(glog[i]), 64'(want));
        end
        check("t3_sb_empty", 64'(exp_q.size()), 64'd0);

        // 4-beat incremental burst from master 1 with master 3 waiting
        do_reset();
        for (int b = 0; b < 4; b++) push_exp(1, 32'h0000_5000 + 32'(4 * b));
        push_exp(3, 32'h0000_5800);
        fork
            master_txn(1, 4, 32'h0000_5000);
            begin
                repeat (2) @(posedge wb_clk_i);
                #1;
                master_txn(3, 1, 32'h0000_5800);
            end
            begin
                int n;
                n = 0;
                @(negedge wb_clk_i);
                while (wbm_cyc_i[1] && n < 200) begin
                    @(negedge wb_clk_i);
                    n++;
                end
                check("t4_grant_at_drop", 64'(grant_o), 64'b0010);
                @(negedge wb_clk_i);
                check("t4_idle_gap", 64'(grant_o), 64'd0);
                @(negedge wb_clk_i);
                check("t4_m3_granted", 64'(grant_o), 64'b1000);
                check("t4_m3_cyc", 64'(wbs_cyc_o), 64'd1);
            end
        join
        @(negedge wb_clk_i);
        check("t4_grant_events", 64'(glog.size()), 64'd2);
        check("t4_first_owner", 64'(glog[0]), 64'b0010);
        check("t4_second_owner", 64'(glog[1]), 64'b1000);
        check("t4_m1_acks", 64'(ack_cnt[1]), 64'd4);
        check("t4_sb_empty", 64'(exp_q.size()), 64'd0);

        // Watchdog: slave never answers master 0
        do_reset();
        slv_dead = 1;
        wbm_adr_i[0 +: 32] = 32'h0000_6000;
        wbm_cti_i[0 +: 3] = CTI_CLASSIC;
        wbm_cyc_i[0] = 1'b1;
        wbm_stb_i[0] = 1'b1;
        begin
            int  wc;
            bit  seen;
            wc = 0;
            seen = 0;
            for (int i = 0; i < 50 && !seen; i++) begin
                @(negedge wb_clk_i);
                if (wbm_err_o[0]) seen = 1;
                else if (wbs_stb_o && !wbs_ack_i && !wbs_err_i && !wbs_rty_i) wc++;
            end
            check("t5_err_seen", 64'(seen), 64'd1);
            check("t5_wait_cycles", 64'(wc), 64'd8);
        end
        check("t5_timeout_pulse", 64'(timeout_o), 64'd1);
        check("t5_cyc_forced_low", 64'(wbs_cyc_o), 64'd0);
        @(posedge wb_clk_i);
        #1 slv_late = 1;
        @(negedge wb_clk_i);
        check("t5_err_one_cycle", 64'(wbm_err_o[0]), 64'd0);
        check("t5_timeout_one_cycle", 64'(timeout_o), 64'd0);
        @(posedge wb_clk_i);
        #1 slv_late = 0;
        @(negedge wb_clk_i);
        check("t5_late_ack_dropped", 64'(wbm_ack_o[0]), 64'd0);
        check("t5_abort_holds_grant", 64'(grant_o), 64'b0001);
        @(posedge wb_clk_i);
        #1;
        wbm_cyc_i[0] = 1'b0;
        wbm_stb_i[0] = 1'b0;
        repeat (2) @(negedge wb_clk_i);
        check("t5_released", 64'(grant_o), 64'd0);
        check("t5_err_count", 64'(err_cnt[0]), 64'd1);
        check("t5_timeout_count", 64'(to_cnt), 64'd1);

        // Reset asserted during the second beat of a burst
        do_reset();
        push_exp(1, 32'h0000_7000);
        fork
            master_txn(1, 4, 32'h0000_7000);
            begin
                int n;
                n = 0;
                @(negedge wb_clk_i);
                while (!wbm_ack_o[1] && n < 50) begin
                    @(negedge wb_clk_i);
                    n++;
                end
                @(posedge wb_clk_i);
                #3;
                abort_all = 1;
                wb_rst_ni = 1'b0;
                #1;
                check("t6_async_cyc", 64'(wbs_cyc_o), 64'd0);
                check("t6_async_stb", 64'(wbs_stb_o), 64'd0);
                check("t6_async_grant", 64'(grant_o), 64'd0);
                check("t6_async_ack", 64'(wbm_ack_o), 64'd0);
                check("t6_async_err", 64'(wbm_err_o), 64'd0);
            end
        join
        repeat (2) @(posedge wb_clk_i);
        #1;
        wb_rst_ni = 1'b1;
        abort_all = 0;
        check("t6_no_err", 64'(err_cnt[1]), 64'd0);
        check("t6_sb_empty", 64'(exp_q.size()), 64'd0);
        clear_logs();
        push_exp(0, 32'h0000_7800);
        push_exp(1, 32'h0000_7900);
        fork
            master_txn(0, 1, 32'h0000_7800);
            master_txn(1, 1, 32'h0000_7900);
        join
        @(negedge wb_clk_i);
        check("t6_grant_events", 64'(glog.size()), 64'd2);
        check("t6_first_after_reset", 64'(glog[0]), 64'b0001);
        check("t6_second_after_reset", 64'(glog[1]), 64'b0010);
        check("t6_sb_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
